blink_monitor: RTL and testbench

BLINK_MONITOR -- requirements
Module: blink_monitor

---
 rtl/blink_monitor.sv | 184 ++++++++++++++++++
 tb/tb_blink_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// -----------------------------------------------------------------------------
// blink_monitor
//
// Measures a slow blink/pulse input (for example an LED drive line) in CLK
// cycles. Each complete rise-to-rise period is reported with its high time,
// and the input is flagged dead when no rise arrives for TIMEOUT cycles.
//
// Parameters
//   CNT_W       width of the cycle counters and measurement outputs
//   TIMEOUT     maximum rise-to-rise distance before the input is declared dead
//
// Ports
//   CLK         system clock; all state changes on the rising edge
//   RSTn        asynchronous active-low reset
//   Sig_in      asynchronous input to measure
//   High_cnt    high time of the last complete period (cycles)
//   Period_cnt  rise-to-rise period of the last complete period (cycles)
//   Meas_valid  one-cycle strobe when High_cnt / Period_cnt update
//   Timeout     level, high while the input is declared dead
// -----------------------------------------------------------------------------
module blink_monitor #(
  parameter int unsigned      CNT_W   = 23,
  parameter logic [CNT_W-1:0] TIMEOUT = 23'd6_000_000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Sig_in,
  output logic [CNT_W-1:0] High_cnt,
  output logic [CNT_W-1:0] Period_cnt,
  output logic             Meas_valid,
  output logic             Timeout
);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  // Input conditioning
  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic rise_s;
  logic fall_s;

  // Free-running distance counter
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit_s;

  // Measurement FSM and registered outputs
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] high_tmp_q;
  logic [CNT_W-1:0] high_tmp_d;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] period_cnt_d;
  logic             meas_valid_q;
  logic             meas_valid_d;
  logic             timeout_q;
  logic             timeout_d;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= Sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Edges are taken from the synchronized copy only; Sig_in itself is never
  // looked at combinationally.
  assign rise_s = sync2_q & ~hist_q;
  assign fall_s = ~sync2_q & hist_q;

  assign at_limit_s = (cnt_q == TIMEOUT);

  // Distance counter: a rise loads 1 so that the value seen on a later edge
  // equals the number of cycles since that rise; saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (rise_s) begin
      cnt_d = CNT_W'(1);
    end else if (at_limit_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Distance counter register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-state and output logic of the measurement FSM.
  always_comb begin
    state_d      = state_q;
    high_tmp_d   = high_tmp_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;

    if (at_limit_s && !rise_s) begin
      // Input dead: drop back to arming. A rise in this very cycle is a
      // legal period of exactly TIMEOUT and is handled below instead.
      state_d   = WAIT_RISE;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        WAIT_RISE: begin
          // First rise after reset or timeout only arms the block.
          if (rise_s) begin
            state_d   = MEAS_HIGH;
            timeout_d = 1'b0;
          end else begin
            state_d = WAIT_RISE;
          end
        end
        MEAS_HIGH: begin
          if (fall_s) begin
            high_tmp_d = cnt_q;
            state_d    = MEAS_LOW;
          end else begin
            state_d = MEAS_HIGH;
          end
        end
        MEAS_LOW: begin
          // A fall here cannot occur after a proper high phase and is ignored.
          if (rise_s) begin
            period_cnt_d = cnt_q;
            high_cnt_d   = high_tmp_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            state_d      = MEAS_HIGH;
          end else begin
            state_d = MEAS_LOW;
          end
        end
        default: begin
          state_d = WAIT_RISE;
        end
      endcase
    end
  end

  // FSM state and measurement registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= WAIT_RISE;
      high_tmp_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_tmp_q   <= high_tmp_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign High_cnt   = high_cnt_q;
  assign Period_cnt = period_cnt_q;
  assign Meas_valid = meas_valid_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_blink_monitor.sv
// -----------------------------------------------------------------------------
// tb_blink_monitor
//
// Directed bench for blink_monitor with TIMEOUT = 100. The stimulus process
// drives pulse shapes and pushes the measurement each rise is expected to
// report; a separate monitor pops and compares on every Meas_valid strobe.
// -----------------------------------------------------------------------------
module tb_blink_monitor;

  localparam int unsigned      CNT_W = 23;
  localparam logic [CNT_W-1:0] TMO   = 23'd100;

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;

  typedef struct {
    int h;
    int p;
    int gap;   // expected cycles since the previous strobe, 0 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int cyc      = 0;
  int last_cyc = 0;

  blink_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .Sig_in     (sig_in),
    .High_cnt   (high_cnt),
    .Period_cnt (period_cnt),
    .Meas_valid (meas_valid),
    .Timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected measurement.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      n_strobe++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got high=%0d period=%0d, expected no strobe (t=%0t)",
                 high_cnt, period_cnt, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("high_cnt", longint'(high_cnt), longint'(mon_e.h));
        chk("period_cnt", longint'(period_cnt), longint'(mon_e.p));
        chk("timeout_on_strobe", longint'(timeout), 0);
        if (mon_e.gap > 0) chk("strobe_gap", longint'(cyc - last_cyc), longint'(mon_e.gap));
      end
      last_cyc = cyc;
    end
  end

  // One rise, h cycles high, l cycles low. Called on a falling clock edge.
  // Optionally queues the measurement this rise completes, and checks the
  // Timeout level two edges after the rise (before it is cleared) and three
  // edges after (always cleared).
  task automatic pulse(input int h, input int l, input bit push,
                       input int eh, input int ep, input int eg, input int exp_to);
    exp_t e;
    sig_in = 1'b1;
    if (push) begin
      e.h = eh; e.p = ep; e.gap = eg;
      sb_q.push_back(e);
    end
    for (int i = 1; i <= h + l; i++) begin
      @(negedge clk);
      sig_in = (i < h);
      if (i == 2 && exp_to >= 0) chk("timeout_before_clear", longint'(timeout), longint'(exp_to));
      if (i == 3) chk("timeout_after_rise", longint'(timeout), 0);
    end
  endtask

  task automatic hold_low(input int n);
    sig_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_high_cnt", longint'(high_cnt), 0);
    chk("rst_period_cnt", longint'(period_cnt), 0);
    chk("rst_meas_valid", longint'(meas_valid), 0);
    chk("rst_timeout", longint'(timeout), 0);
    rst_n = 1'b1;

    // Square wave 4 high / 6 low: first rise arms, then one strobe per rise.
    pulse(4, 6, 1'b0, 0, 0, 0, 0);
    pulse(4, 6, 1'b1, 4, 10, 0, 0);
    for (int k = 0; k < 4; k++) pulse(4, 6, 1'b1, 4, 10, 10, 0);

    // Dead input: Timeout rises, measurements hold.
    hold_low(120);
    chk("dead_timeout", longint'(timeout), 1);
    chk("dead_high_hold", longint'(high_cnt), 4);
    chk("dead_period_hold", longint'(period_cnt), 10);

    // 1-high pulse every 3 cycles; first rise clears Timeout without a strobe.
    pulse(1, 2, 1'b0, 0, 0, 0, 1);
    pulse(1, 2, 1'b1, 1, 3, 0, 0);
    for (int k = 0; k < 3; k++) pulse(1, 2, 1'b1, 1, 3, 3, 0);
    hold_low(120);
    chk("dead2_timeout", longint'(timeout), 1);
    chk("dead2_high_hold", longint'(high_cnt), 1);
    chk("dead2_period_hold", longint'(period_cnt), 3);

    // Asynchronous reset mid-cycle while the input toggles.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          sig_in = (i % 2 == 0);
          @(negedge clk);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_high_cnt", longint'(high_cnt), 0);
        chk("async_rst_period_cnt", longint'(period_cnt), 0);
        chk("async_rst_meas_valid", longint'(meas_valid), 0);
        chk("async_rst_timeout", longint'(timeout), 0);
      end
    join

    // Release with the input already high: that rise only arms.
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse(4, 6, 1'b0, 0, 0, 0, 0);
    pulse(4, 6, 1'b1, 4, 10, 0, 0);
    pulse(4, 6, 1'b1, 4, 10, 10, 0);
    hold_low(120);
    chk("dead3_timeout", longint'(timeout), 1);

    // Boundary: period of exactly TIMEOUT measures; TIMEOUT+1 times out.
    pulse(4, 96, 1'b0, 0, 0, 0, 1);
    pulse(4, 97, 1'b1, 4, 100, 0, 0);
    pulse(4, 6, 1'b0, 0, 0, 0, 1);
    pulse(4, 6, 1'b1, 4, 10, 0, 0);
    pulse(4, 6, 1'b1, 4, 10, 10, 0);
    hold_low(20);

    chk("scoreboard_empty", longint'(sb_q.size()), 0);
    chk("strobe_count", longint'(n_strobe), 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
